// File: rtl/pixel_writeback_fifo.sv
// Buffers extended pixels from the raycaster and writes each one to the framebuffer
// as three 32-bit beats (word0, word1, word2) on a valid/ready memory port.
//
// state  | meaning
// S_IDLE | nothing in flight, mem_valid low
// S_W0   | presenting word0 of the head pixel
// S_W1   | presenting word1 of the head pixel
// S_W2   | presenting word2; head entry is popped when it is accepted
module pixel_writeback_fifo #(
    parameter int          DEPTH   = 8,
    parameter logic [31:0] FB_BASE = 32'h0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             pix_word0,
    input  logic [31:0]             pix_word1,
    input  logic [31:0]             pix_word2,
    input  logic [31:0]             pix_addr,
    input  logic                    pix_we,
    input  logic                    frame_done,
    input  logic                    clear_status,
    output logic [31:0]             mem_addr,
    output logic [31:0]             mem_wdata,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    overflow,
    output logic [15:0]             drop_count,
    output logic                    frame_flushed,
    output logic                    busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = DEPTH[AW:0];
    localparam logic [AW:0] LVL_ONE  = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_W0, S_W1, S_W2} state_t;
    state_t state, state_nxt;

    logic [31:0]   q_w0 [DEPTH];
    logic [31:0]   q_w1 [DEPTH];
    logic [31:0]   q_w2 [DEPTH];
    logic [31:0]   q_pa [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [AW-1:0] head_idx, next_idx;
    logic          full, empty, accept, pop, push_ok, drop;
    logic          flush_pending, flush_cond;
    logic          load_en, valid_nxt;
    logic [31:0]   ld_addr, ld_data;
    logic [15:0]   drop_base;

    function automatic logic [31:0] pix_base(input logic [31:0] a);
        return FB_BASE + (a << 3) + (a << 2);
    endfunction

    assign fifo_level = wr_ptr - rd_ptr;
    assign head_idx   = rd_ptr[AW-1:0];
    assign next_idx   = head_idx + 1'b1;
    assign full       = (fifo_level == LVL_FULL);
    assign empty      = (fifo_level == '0);
    assign accept     = mem_valid & mem_ready;
    assign pop        = (state == S_W2) & accept;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign push_ok    = pix_we & (~full | pop);
    assign drop       = pix_we & full & ~pop;
    assign busy       = ~empty | (state != S_IDLE);
    assign flush_cond = flush_pending & empty & (state == S_IDLE) & ~pix_we;
    assign drop_base  = clear_status ? 16'h0 : drop_count;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            q_w0[wr_ptr[AW-1:0]] <= pix_word0;
            q_w1[wr_ptr[AW-1:0]] <= pix_word1;
            q_w2[wr_ptr[AW-1:0]] <= pix_word2;
            q_pa[wr_ptr[AW-1:0]] <= pix_addr;
        end
    end

    always_comb begin
        state_nxt = state;
        valid_nxt = mem_valid;
        load_en   = 1'b0;
        ld_addr   = mem_addr;
        ld_data   = mem_wdata;
        case (state)
            S_IDLE: if (!empty) begin
                state_nxt = S_W0;
                valid_nxt = 1'b1;
                load_en   = 1'b1;
                ld_addr   = pix_base(q_pa[head_idx]);
                ld_data   = q_w0[head_idx];
            end
            S_W0: if (accept) begin
                state_nxt = S_W1;
                load_en   = 1'b1;
                ld_addr   = mem_addr + 32'd4;
                ld_data   = q_w1[head_idx];
            end
            S_W1: if (accept) begin
                state_nxt = S_W2;
                load_en   = 1'b1;
                ld_addr   = mem_addr + 32'd4;
                ld_data   = q_w2[head_idx];
            end
            S_W2: if (accept) begin
                // Chain straight into the next pixel; if the only other entry is
                // arriving on this very edge, take it from the input pins.
                if (fifo_level != LVL_ONE) begin
                    state_nxt = S_W0;
                    load_en   = 1'b1;
                    ld_addr   = pix_base(q_pa[next_idx]);
                    ld_data   = q_w0[next_idx];
                end else if (push_ok) begin
                    state_nxt = S_W0;
                    load_en   = 1'b1;
                    ld_addr   = pix_base(pix_addr);
                    ld_data   = pix_word0;
                end else begin
                    state_nxt = S_IDLE;
                    valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            mem_valid     <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            overflow      <= 1'b0;
            drop_count    <= '0;
            flush_pending <= 1'b0;
            frame_flushed <= 1'b0;
        end else begin
            state     <= state_nxt;
            mem_valid <= valid_nxt;
            if (load_en) begin
                mem_addr  <= ld_addr;
                mem_wdata <= ld_data;
            end
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            // A drop on the same edge as clear_status leaves the flag set with a count of one.
            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= (drop_base == 16'hFFFF) ? drop_base : drop_base + 16'd1;
            end else if (clear_status) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end
            frame_flushed <= flush_cond;
            flush_pending <= flush_cond ? 1'b0 : (flush_pending | frame_done);
        end
    end
endmodule
